// File: rtl/raster_scan_gen.sv
// raster_scan_gen
// Two-dimensional raster scan generator for the edge-detection datapath.
// A frame is started from IDLE. At that point the column/row limits, the base
// address and the row pitch are latched. The block then emits one
// (x, y, address) beat per valid/ready handshake. x is the fast index.
// Each beat carries position flags for the 3x3 window logic and the read master.
// Ports:
//   clk_i, rst_i          clock (rising edge) and asynchronous active-high reset
//   start_i, abort_i      frame start (honoured in IDLE) and synchronous abort
//   x_last_i, y_last_i    last column / last row index, latched on start
//   base_i, pitch_i       address of pixel (0,0) and row stride, latched on start
//   ready_i / valid_o     beat handshake
//   x_o, y_o, addr_o      current beat position and address
//   first_o, row_end_o, last_o, border_o   beat position flags
//   busy_o, done_o        frame in progress / one-cycle completion pulse
module raster_scan_gen #(
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int ADDR_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [X_W-1:0]    x_last_i,
    input  logic [Y_W-1:0]    y_last_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] pitch_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              first_o,
    output logic              row_end_o,
    output logic              last_o,
    output logic              border_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [X_W-1:0]      x_last_q, x_last_d;
    logic [Y_W-1:0]      y_last_q, y_last_d;
    logic [ADDR_W-1:0]   pitch_q, pitch_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                row_end_s;
    logic                col_end_s;
    logic                last_s;
    logic [ADDR_W-1:0]   next_row_base_s;

    // Position decode against the latched limits.
    always_comb begin
        row_end_s       = (x_q == x_last_q);
        col_end_s       = (y_q == y_last_q);
        last_s          = row_end_s && col_end_s;
        // The next row start is reached by adding the pitch once, so no multiplier is needed.
        next_row_base_s = row_base_q + pitch_q;
    end

    // Next-state, scan counters and address stepping.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        x_last_d   = x_last_q;
        y_last_d   = y_last_q;
        pitch_d    = pitch_q;

        if (abort_i) begin
            // Abort overrides start and any pending handshake.
            state_d    = ST_IDLE;
            x_d        = {X_W{1'b0}};
            y_d        = {Y_W{1'b0}};
            addr_d     = {ADDR_W{1'b0}};
            row_base_d = {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d    = ST_RUN;
                        x_last_d   = x_last_i;
                        y_last_d   = y_last_i;
                        pitch_d    = pitch_i;
                        row_base_d = base_i;
                        addr_d     = base_i;
                        x_d        = {X_W{1'b0}};
                        y_d        = {Y_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (ready_i) begin
                        if (last_s) begin
                            // The final beat holds its position through DONE.
                            state_d = ST_DONE;
                        end else if (!row_end_s) begin
                            x_d    = x_q + {{(X_W-1){1'b0}}, 1'b1};
                            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end else begin
                            x_d        = {X_W{1'b0}};
                            y_d        = y_q + {{(Y_W-1){1'b0}}, 1'b1};
                            row_base_d = next_row_base_s;
                            addr_d     = next_row_base_s;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // A start_i here is deliberately ignored.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state.
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, counters, latched frame parameters and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            x_q        <= {X_W{1'b0}};
            y_q        <= {Y_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            row_base_q <= {ADDR_W{1'b0}};
            x_last_q   <= {X_W{1'b0}};
            y_last_q   <= {Y_W{1'b0}};
            pitch_q    <= {ADDR_W{1'b0}};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            x_last_q   <= x_last_d;
            y_last_q   <= y_last_d;
            pitch_q    <= pitch_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign addr_o    = addr_q;
    assign first_o   = (x_q == {X_W{1'b0}}) && (y_q == {Y_W{1'b0}});
    assign row_end_o = row_end_s;
    assign last_o    = last_s;
    assign border_o  = (x_q == {X_W{1'b0}}) || (y_q == {Y_W{1'b0}}) || row_end_s || col_end_s;

endmodule

// File: doc/raster_scan_gen.md
# raster_scan_gen

- Parametrised 2-D raster scan generator for the edge-detection datapath.
- Per frame, it latches run-time width/height limits plus a base address and row pitch, then emits one (x, y, address) beat per valid/ready handshake.
- Each beat carries frame/row/border position flags that the 3x3 window logic and the Avalon read master consume.
- Replaces the fixed-bound dual-port counter: bounds are run-time, x is the fast index, and it adds back-pressure, address generation, abort and a completion pulse.

## Interface
Parameters:
- X_W, 10, width of x_o and x_last_i
- Y_W, 10, width of y_o and y_last_i
- ADDR_W, 24, width of base_i, pitch_i, addr_o

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start a frame; honoured only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE from any state, no done_o pulse
- x_last_i  in  X_W  last column index (width-1); latched on start
- y_last_i  in  Y_W  last row index (height-1); latched on start
- base_i  in  ADDR_W  address of pixel (0,0); latched on start
- pitch_i  in  ADDR_W  address distance between rows; latched on start
- ready_i  in  1  consumer accepts current beat
- valid_o  out  1  beat valid
- x_o  out  X_W  current column
- y_o  out  Y_W  current row
- addr_o  out  ADDR_W  base + y*pitch + x, modulo 2^ADDR_W
- first_o  out  1  x==0 && y==0
- row_end_o  out  1  x==x_last
- last_o  out  1  x==x_last && y==y_last
- border_o  out  1  x==0 || y==0 || x==x_last || y==y_last
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after the final beat is accepted

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid_o=0.
  - On start_i (abort_i low): latch x_last, y_last, base, pitch; set x=0, y=0, row_base=base, addr=base; go to RUN.
- RUN:
  - valid_o=1. A beat advances only when valid_o && ready_i at a clock edge.
  - Beat not last:
    - If x!=x_last: x+=1, addr+=1.
    - Else: x=0, y+=1, row_base+=pitch, addr=row_base+pitch.
  - Beat is last: go to DONE; x, y, addr hold.
  - ready_i low: all outputs hold, including flags.
- DONE:
  - done_o=1, valid_o=0 for exactly one cycle, then IDLE.
  - start_i in DONE is ignored.
- abort_i has priority over start_i and handshakes.
  - Next state IDLE; x, y, addr cleared to 0; done_o stays 0.
- Address arithmetic:
  - Incremental only; no multiplier.
  - All sums truncated to ADDR_W (wrap-around allowed, not flagged).
  - pitch_i < x_last+1 is legal: rows overlap, no check.
- Flags:
  - Combinational from the x/y registers and latched limits.
  - Meaningful only while valid_o=1.
- Degenerate frames:
  - x_last=0: every beat is row_end_o.
  - x_last=0, y_last=0: single beat with first_o=last_o=row_end_o=border_o=1.
- Input limits change mid-frame: no effect until the next start.

## Timing
- Reset values (all outputs): valid_o=0, busy_o=0, done_o=0, x_o=0, y_o=0, addr_o=0; state IDLE.
- Flag values at reset follow the zeroed registers and are don't-care while valid_o=0.
- start_i sampled at edge T → valid_o=1 and busy_o=1 from T+1; first beat shows x=0, y=0, addr=base.
- Throughput: one beat per cycle with ready_i held high.
- A frame of W*H pixels with ready_i held high, started at edge T:
  - last beat accepted at edge T+W*H.
  - done_o high during cycle T+W*H+1.
  - IDLE at T+W*H+2; the earliest next start is accepted at that edge.
- Reset mid-frame: immediate return to the reset state, regardless of clock.

## Test plan
- Frame 4x3, base=0x100, pitch=4, ready_i=1:
  - 12 beats; addr 0x100..0x10B contiguous.
  - row_end_o on x=3; last_o only on (3,2); done_o pulse one cycle after.
- Frame 3x2, base=0x0, pitch=8:
  - addr sequence 0,1,2,8,9,10.
  - border_o=1 on all beats; first_o only on beat 0.
- Back-pressure, 3x3 frame, ready_i toggling 1,0,0,1,...:
  - x/y/addr stable while ready_i=0; exactly 9 accepted beats, no skips or duplicates.
- Degenerate 1x1 frame:
  - a single beat with first_o=last_o=row_end_o=border_o=1, then done_o.
- Wrap-around, ADDR_W=24, base=0xFFFFFE, 4x1 frame:
  - addr 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Abort and reset:
  - abort_i at beat 5 of a 4x4 frame → IDLE, no done_o; start_i during DONE ignored.
  - rst_i mid-frame clears all outputs asynchronously; a new start works normally afterwards.
